// File: rtl/vector_execute_mc_if.sv
// Bundle of the vector execute stage's pipeline-side signals.
// The master side is the pipeline and the slave side is the execute unit.
interface vector_execute_mc_if #(
    parameter int V = 256,
    parameter int R = 5
);
    logic         StartE;
    logic         FlushE;
    logic [2:0]   ALUControlE;
    logic [1:0]   ForwardAVE;
    logic [1:0]   ForwardBVE;
    logic [V-1:0] VRD1E;
    logic [V-1:0] VRD2E;
    logic [V-1:0] ResultVW;
    logic [V-1:0] ALUResultVM;
    logic [R-1:0] WA3Ei;
    logic         RegWriteVEi;
    logic [V-1:0] ALUResultVE;
    logic [V-1:0] WriteDataVE;
    logic [R-1:0] WA3Eo;
    logic         RegWriteVEo;
    logic         DoneE;
    logic         BusyE;
    logic         StallE;

    modport master (
        output StartE, FlushE, ALUControlE, ForwardAVE, ForwardBVE,
               VRD1E, VRD2E, ResultVW, ALUResultVM, WA3Ei, RegWriteVEi,
        input  ALUResultVE, WriteDataVE, WA3Eo, RegWriteVEo, DoneE, BusyE, StallE
    );

    modport slave (
        input  StartE, FlushE, ALUControlE, ForwardAVE, ForwardBVE,
               VRD1E, VRD2E, ResultVW, ALUResultVM, WA3Ei, RegWriteVEi,
        output ALUResultVE, WriteDataVE, WA3Eo, RegWriteVEo, DoneE, BusyE, StallE
    );
endinterface

// File: rtl/vector_execute_mc.sv
// Multi-cycle vector ALU: captures two V-bit operands, then processes P lanes
// of W bits per cycle over C = V/(W*P) cycles before pulsing DoneE.
module vector_execute_mc #(
    parameter int V = 256,
    parameter int W = 8,
    parameter int P = 8,
    parameter int R = 5
) (
    input logic               clk,
    input logic               rst,
    vector_execute_mc_if.slave bus
);
    localparam int CHW   = W * P;
    localparam int C     = V / CHW;
    localparam int CNT_W = (C > 1) ? $clog2(C) : 1;

    generate
        if ((V % CHW) != 0) begin : gBadWidth
            $error("vector_execute_mc: V must be divisible by W*P");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [V-1:0]     aOp_q, aOp_d;
    logic [V-1:0]     bOp_q, bOp_d;
    logic [2:0]       op_q, op_d;
    logic [R-1:0]     wa3_q, wa3_d;
    logic             regWrite_q, regWrite_d;
    logic [V-1:0]     result_q, result_d;

    logic [V-1:0]     muxA;
    logic [V-1:0]     muxB;
    logic [CHW-1:0]   aChunk;
    logic [CHW-1:0]   bChunk;
    logic [CHW-1:0]   chunkRes;
    logic [W-1:0]     laneA;
    logic [W-1:0]     laneB;
    logic [W-1:0]     laneR;

    function automatic logic [V-1:0] selOperand(
        input logic [1:0]   sel,
        input logic [V-1:0] regData,
        input logic [V-1:0] fwdW,
        input logic [V-1:0] fwdM
    );
        case (sel)
            2'b00:   return regData;
            2'b01:   return fwdW;
            2'b10:   return fwdM;
            default: return '0;
        endcase
    endfunction

    assign muxA = selOperand(bus.ForwardAVE, bus.VRD1E, bus.ResultVW, bus.ALUResultVM);
    assign muxB = selOperand(bus.ForwardBVE, bus.VRD2E, bus.ResultVW, bus.ALUResultVM);

    always_comb begin
        aChunk = '0;
        bChunk = '0;
        for (int c = 0; c < C; c++) begin
            if (cnt_q == CNT_W'(c)) begin
                aChunk = aOp_q[c*CHW +: CHW];
                bChunk = bOp_q[c*CHW +: CHW];
            end
        end
    end

    // Each lane is computed at exactly W bits, so carries and shifted-out bits never reach a neighbour.
    always_comb begin
        chunkRes = '0;
        laneA    = '0;
        laneB    = '0;
        laneR    = '0;
        for (int l = 0; l < P; l++) begin
            laneA = aChunk[l*W +: W];
            laneB = bChunk[l*W +: W];
            case (op_q)
                3'b000:  laneR = laneA + laneB;
                3'b001:  laneR = laneA - laneB;
                3'b010:  laneR = laneA & laneB;
                3'b011:  laneR = laneA | laneB;
                3'b100:  laneR = laneA ^ laneB;
                3'b101:  laneR = laneB;
                3'b110:  laneR = laneA << 1;
                default: laneR = laneA >> 1;
            endcase
            chunkRes[l*W +: W] = laneR;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        aOp_d      = aOp_q;
        bOp_d      = bOp_q;
        op_d       = op_q;
        wa3_d      = wa3_q;
        regWrite_d = regWrite_q;
        result_d   = result_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.StartE) begin
                    aOp_d      = muxA;
                    bOp_d      = muxB;
                    op_d       = bus.ALUControlE;
                    wa3_d      = bus.WA3Ei;
                    regWrite_d = bus.RegWriteVEi;
                    cnt_d      = '0;
                    result_d   = '0;
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int c = 0; c < C; c++) begin
                    if (cnt_q == CNT_W'(c)) begin
                        result_d[c*CHW +: CHW] = chunkRes;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(C - 1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over any capture decided above.
        if (bus.FlushE) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            aOp_q      <= '0;
            bOp_q      <= '0;
            op_q       <= '0;
            wa3_q      <= '0;
            regWrite_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aOp_q      <= aOp_d;
            bOp_q      <= bOp_d;
            op_q       <= op_d;
            wa3_q      <= wa3_d;
            regWrite_q <= regWrite_d;
            result_q   <= result_d;
        end
    end

    assign bus.ALUResultVE = result_q;
    assign bus.WriteDataVE = bOp_q;
    assign bus.WA3Eo       = wa3_q;
    assign bus.DoneE       = (state_q == DONE);
    assign bus.RegWriteVEo = (state_q == DONE) && regWrite_q;
    assign bus.BusyE       = (state_q != IDLE);
    assign bus.StallE      = (state_q == RUN) ||
                             (((state_q == IDLE) || (state_q == DONE)) && bus.StartE);
endmodule

// File: tb/tb_vector_execute_mc.sv
// Directed self-checking bench for vector_execute_mc with default parameters
// (V=256, W=8, P=8, so four chunks and a five-cycle start-to-done latency).
module tb_vector_execute_mc;
    localparam int V = 256;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    vector_execute_mc_if #(.V(V), .R(R)) vif ();

    vector_execute_mc #(.V(V), .W(8), .P(8), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    function automatic logic [V-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic checkOutput(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Moves to the middle of the next cycle and drives the control inputs for it.
    task automatic applyStimulus(input logic start, input logic flush);
        @(negedge clk);
        vif.StartE = start;
        vif.FlushE = flush;
        #1;
    endtask

    task automatic setOperands(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [V-1:0] rd1, input logic [V-1:0] rd2,
                               input logic [V-1:0] resW, input logic [V-1:0] aluM,
                               input logic [R-1:0] wa, input logic rwe);
        vif.ALUControlE = op;
        vif.ForwardAVE  = fa;
        vif.ForwardBVE  = fb;
        vif.VRD1E       = rd1;
        vif.VRD2E       = rd2;
        vif.ResultVW    = resW;
        vif.ALUResultVM = aluM;
        vif.WA3Ei       = wa;
        vif.RegWriteVEi = rwe;
        #1;
    endtask

    task automatic runAndCheck(input string tag, input logic [2:0] op, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [V-1:0] rd1, input logic [V-1:0] rd2,
                               input logic [V-1:0] resW, input logic [V-1:0] aluM,
                               input logic [V-1:0] exp);
        int found;
        found = 0;
        setOperands(op, fa, fb, rd1, rd2, resW, aluM, 5'd9, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (vif.DoneE === 1'b1) begin
                found = i;
                break;
            end
        end
        checkOutput({tag, "_latency"}, found, 5);
        checkOutput({tag, "_result"}, vif.ALUResultVE, exp);
        applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        vif.StartE = 1'b0;
        vif.FlushE = 1'b0;
        setOperands(3'b000, 2'b00, 2'b00, '0, '0, '0, '0, '0, 1'b0);

        // Reset held for two cycles
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_alu", vif.ALUResultVE, '0);
        checkOutput("rst_wdata", vif.WriteDataVE, '0);
        checkOutput("rst_wa3", vif.WA3Eo, '0);
        checkOutput("rst_done", vif.DoneE, '0);
        checkOutput("rst_regwrite", vif.RegWriteVEo, '0);
        checkOutput("rst_busy", vif.BusyE, '0);
        checkOutput("rst_stall", vif.StallE, '0);
        rst = 1'b0;

        // Lane-wise add with wraparound, operands scrambled after capture
        setOperands(3'b000, 2'b00, 2'b00, rep(8'hFF), rep(8'h01), rep(8'hC3), rep(8'h3C), 5'd3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("add_stall_t0", vif.StallE, 1);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0);
            setOperands(3'b111, 2'b11, 2'b11, rep(8'hAA), rep(8'hAA), rep(8'hAA), rep(8'hAA), 5'd0, 1'b0);
            checkOutput($sformatf("add_done_c%0d", i), vif.DoneE, (i == 5) ? 1 : 0);
            checkOutput($sformatf("add_stall_c%0d", i), vif.StallE, (i <= 4) ? 1 : 0);
            checkOutput($sformatf("add_busy_c%0d", i), vif.BusyE, (i <= 5) ? 1 : 0);
            if (i == 5) begin
                checkOutput("add_result", vif.ALUResultVE, '0);
                checkOutput("add_regwrite", vif.RegWriteVEo, 1);
                checkOutput("add_wa3", vif.WA3Eo, 5'd3);
                checkOutput("add_wdata", vif.WriteDataVE, rep(8'h01));
            end
        end
        checkOutput("add_hold_wdata", vif.WriteDataVE, rep(8'h01));
        checkOutput("add_idle_regwrite", vif.RegWriteVEo, 0);

        // A forwarded from the memory stage; later changes to it are ignored
        setOperands(3'b100, 2'b10, 2'b00, rep(8'h33), rep(8'h0F), rep(8'h77), rep(8'h10), 5'd7, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        setOperands(3'b100, 2'b10, 2'b00, rep(8'h33), rep(8'h0F), rep(8'h77), rep(8'hAA), 5'd7, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("fwd_chunk0", vif.ALUResultVE, {192'b0, {8{8'h1F}}});
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("fwd_done", vif.DoneE, 1);
        checkOutput("fwd_result", vif.ALUResultVE, rep(8'h1F));
        checkOutput("fwd_regwrite", vif.RegWriteVEo, 0);
        checkOutput("fwd_wa3", vif.WA3Eo, 5'd7);
        applyStimulus(1'b0, 1'b0);

        // Back-to-back: OR with zero A and W-stage B, then sub restarted from DONE
        setOperands(3'b011, 2'b11, 2'b01, rep(8'h99), rep(8'h99), rep(8'h5A), rep(8'h66), 5'd12, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (i == 1) begin
                setOperands(3'b001, 2'b00, 2'b00, rep(8'h05), rep(8'h07), rep(8'h11), rep(8'h22), 5'd21, 1'b1);
            end
            checkOutput($sformatf("b2b_busy_c%0d", i), vif.BusyE, 1);
            checkOutput($sformatf("b2b_done_c%0d", i), vif.DoneE, 0);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("b2b_op1_done", vif.DoneE, 1);
        checkOutput("b2b_op1_result", vif.ALUResultVE, rep(8'h5A));
        checkOutput("b2b_op1_regwrite", vif.RegWriteVEo, 1);
        checkOutput("b2b_op1_wa3", vif.WA3Eo, 5'd12);
        checkOutput("b2b_op1_stall", vif.StallE, 1);
        checkOutput("b2b_op1_busy", vif.BusyE, 1);
        for (int i = 6; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("b2b_busy_c%0d", i), vif.BusyE, 1);
            checkOutput($sformatf("b2b_done_c%0d", i), vif.DoneE, (i == 10) ? 1 : 0);
            if (i == 6) begin
                checkOutput("b2b_op2_cleared", vif.ALUResultVE, '0);
            end
        end
        checkOutput("b2b_op2_result", vif.ALUResultVE, rep(8'hFE));
        checkOutput("b2b_op2_wa3", vif.WA3Eo, 5'd21);
        checkOutput("b2b_op2_wdata", vif.WriteDataVE, rep(8'h07));
        applyStimulus(1'b0, 1'b0);
        checkOutput("b2b_idle_busy", vif.BusyE, 0);

        // Flush in RUN, together with a StartE that must lose
        setOperands(3'b000, 2'b00, 2'b00, rep(8'h01), rep(8'h01), '0, '0, 5'd4, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("flush_pre_result", vif.ALUResultVE, {192'b0, {8{8'h02}}});
        checkOutput("flush_pre_stall", vif.StallE, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("flush_busy", vif.BusyE, 0);
        checkOutput("flush_result", vif.ALUResultVE, '0);
        for (int i = 3; i <= 7; i++) begin
            checkOutput($sformatf("flush_done_c%0d", i), vif.DoneE, 0);
            checkOutput($sformatf("flush_regwrite_c%0d", i), vif.RegWriteVEo, 0);
            applyStimulus(1'b0, 1'b0);
        end

        // Reset during RUN chunk 1 discards the shift operation
        setOperands(3'b110, 2'b00, 2'b00, 256'h81, '0, '0, '0, 5'd2, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("mixed_rst_busy", vif.BusyE, 0);
        checkOutput("mixed_rst_result", vif.ALUResultVE, '0);
        checkOutput("mixed_rst_wdata", vif.WriteDataVE, '0);
        checkOutput("mixed_rst_wa3", vif.WA3Eo, '0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("mixed_rst_nodone_%0d", i), vif.DoneE, 0);
        end

        runAndCheck("shl", 3'b110, 2'b00, 2'b00, 256'h81, '0, '0, '0, 256'h02);
        runAndCheck("shr", 3'b111, 2'b00, 2'b00, rep(8'h81), '0, '0, '0, rep(8'h40));
        runAndCheck("and", 3'b010, 2'b00, 2'b00, rep(8'hF0), rep(8'h3C), '0, '0, rep(8'h30));
        runAndCheck("nocarry", 3'b000, 2'b00, 2'b00, rep(8'h81), rep(8'h80), '0, '0, rep(8'h01));
        runAndCheck("passb_m", 3'b101, 2'b00, 2'b10, rep(8'h11), rep(8'h22), rep(8'h33), rep(8'hC7), rep(8'hC7));
        runAndCheck("fwdA_w", 3'b000, 2'b01, 2'b11, rep(8'h11), rep(8'h22), rep(8'h10), rep(8'h44), rep(8'h10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_execute_mc.md
VECTOR_EXECUTE_MC -- requirements
Module: vector_execute_mc

Interface
REQ-001 Parameter V, default 256, vector operand width in bits.
REQ-002 Parameter W, default 8, lane width in bits.
REQ-003 Parameter P, default 8, lanes processed per cycle; C = V/(W*P) chunks, default 4.
REQ-004 Parameter R, default 5, register address width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 StartE  in  1  request to launch one vector operation.
REQ-008 FlushE  in  1  synchronous abort of any operation in flight.
REQ-009 ALUControlE  in  3  operation select.
REQ-010 ForwardAVE, ForwardBVE  in  2 each  operand source selects.
REQ-011 VRD1E, VRD2E, ResultVW, ALUResultVM  in  V each  operand candidates.
REQ-012 WA3Ei  in  R  destination register; RegWriteVEi  in  1  write enable of the operation.
REQ-013 ALUResultVE  out  V  registered result; WriteDataVE  out  V  captured B operand.
REQ-014 WA3Eo  out  R  captured destination; RegWriteVEo  out  1  write strobe.
REQ-015 DoneE  out  1  result-valid pulse; BusyE  out  1  unit occupied; StallE  out  1  upstream stall request.

Function
REQ-016 Operand mux select encoding SHALL be: 00 register data, 01 ResultVW, 10 ALUResultVM, 11 all zeros.
REQ-017 FSM states SHALL be IDLE, RUN and DONE; state SHALL be IDLE after reset.
REQ-018 IDLE with StartE=1 SHALL capture the muxed A and B operands, ALUControlE, WA3Ei and RegWriteVEi, clear the chunk counter, clear ALUResultVE and enter RUN.
REQ-019 Input changes after the capture edge SHALL NOT affect the operation.
REQ-020 RUN cycle k SHALL compute lanes k*P through k*P+P-1 into ALUResultVE bits [(k+1)*P*W-1 : k*P*W] and increment k; when k=C-1 the FSM SHALL enter DONE.
REQ-021 Per-lane operations SHALL be: 000 add mod 2^W; 001 A-B mod 2^W; 010 AND; 011 OR; 100 XOR; 101 pass B; 110 logical shift left by 1; 111 logical shift right by 1. No carry SHALL cross lane boundaries.
REQ-022 DONE SHALL last exactly one cycle with DoneE=1 and RegWriteVEo equal to the captured RegWriteVEi; both SHALL be 0 in every other state.
REQ-023 In DONE, StartE=1 SHALL perform the REQ-018 capture and enter RUN; otherwise the FSM SHALL enter IDLE.
REQ-024 Latency: StartE accepted at edge t SHALL produce DoneE in cycle t+C+1; with C=1 this is t+2.
REQ-025 BusyE SHALL be 1 in RUN and DONE.
REQ-026 StallE SHALL be 1 in RUN, and combinationally 1 in IDLE or DONE when StartE=1.
REQ-027 ALUResultVE, WriteDataVE and WA3Eo SHALL hold their values from DONE until the next capture.
REQ-028 FlushE=1 SHALL force IDLE at the next edge and clear ALUResultVE, DoneE and RegWriteVEo; FlushE SHALL override a simultaneous StartE.
REQ-029 Elaboration SHALL fail if V is not divisible by W*P.

Reset
REQ-030 rst SHALL override FlushE and StartE.
REQ-031 rst SHALL set state to IDLE, the chunk counter to 0, all V-wide outputs to 0, WA3Eo to 0, and DoneE, RegWriteVEo and BusyE to 0.
REQ-032 rst asserted mid-operation SHALL discard that operation; no DoneE SHALL follow.

Verification
REQ-033 Reset: with rst=1 for 2 cycles, every output SHALL be 0 and StallE SHALL be 0 while StartE=0.
REQ-034 Add: VRD1E lanes 0xFF, VRD2E lanes 0x01, op 000, Forward=00, StartE at t -> ALUResultVE all 0x00; DoneE=1 only in cycle t+5; StallE=1 in cycles t through t+4.
REQ-035 Forwarding: ForwardAVE=10 with ALUResultVM lanes 0x10, VRD2E lanes 0x0F, op 100; ALUResultVM changed to 0xAA after t -> result lanes 0x1F.
REQ-036 Flush: FlushE at t+2 of a running op with RegWriteVEi=1 -> IDLE at t+3, ALUResultVE=0, no DoneE, RegWriteVEo stays 0.
REQ-037 Back-to-back: second StartE held in the DONE cycle of op 1 (sub, A lanes 0x05, B lanes 0x07) -> op 2 DoneE exactly 5 cycles later, result lanes 0xFE, BusyE continuously 1.
REQ-038 Mixed: op 110 with A lane0 0x81 and other lanes 0x00; rst pulsed in RUN k=1 -> no DoneE. Rerun without rst -> lane0 0x02, other lanes 0x00.
